// File: rtl/clkgen_pkg.sv
// Shared types and defaults for the clk_div_pwm divider.
package clkgen_pkg;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefPeriod = 10;
  localparam int unsigned DefHigh   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/clk_div_pwm_if.sv
// Configuration valid/ready port for clk_div_pwm.
interface clk_div_pwm_if
  import clkgen_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_high;

  modport master (output cfg_valid, output cfg_period, output cfg_high, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_period, input cfg_high, output cfg_ready);

endinterface

// File: rtl/clk_div_pwm.sv
// Programmable clock divider with duty control; new period/high values are
// shadowed and only take effect at period boundaries so clk_out never glitches.
module clk_div_pwm
  import clkgen_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned DEF_PERIOD = DefPeriod,
  parameter int unsigned DEF_HIGH   = DefHigh
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  clk_div_pwm_if.slave  cfg,
  output logic          clk_out,
  output logic          tick,
  output logic          running
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] pper_q, pper_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic             pending_q, pending_d;
  logic             ready_q, ready_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             accept, last, boundary;

  assign accept   = cfg.cfg_valid && ready_q;
  assign last     = (cnt_q == per_q - WIDTH'(1));
  assign boundary = (state_q == StIdle) || last;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    hi_d      = hi_q;
    pper_d    = pper_q;
    phi_d     = phi_q;
    pending_d = pending_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable) state_d = StRun;
      end
      StRun: begin
        cnt_d = last ? '0 : cnt_q + WIDTH'(1);
        // Dropping enable on the last cycle has nothing left to drain.
        if (!enable) state_d = last ? StIdle : StDrain;
      end
      StDrain: begin
        cnt_d = last ? '0 : cnt_q + WIDTH'(1);
        if (enable)    state_d = StRun;
        else if (last) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // accept requires ready, so it never coincides with a pending apply.
    if (boundary && pending_q) begin
      per_d     = pper_q;
      hi_d      = phi_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      pper_d    = (cfg.cfg_period == '0) ? WIDTH'(1) : cfg.cfg_period;
      phi_d     = cfg.cfg_high;
      pending_d = 1'b1;
    end

    ready_d   = !pending_d;
    clk_out_d = (state_d != StIdle) && (cnt_d < hi_d);
    tick_d    = (state_d != StIdle) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      per_q     <= WIDTH'(DEF_PERIOD);
      hi_q      <= WIDTH'(DEF_HIGH);
      pper_q    <= '0;
      phi_q     <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      hi_q      <= hi_d;
      pper_q    <= pper_d;
      phi_q     <= phi_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign clk_out       = clk_out_q;
  assign tick          = tick_q;
  assign running       = (state_q != StIdle);

endmodule

// File: tb/tb_clk_div_pwm.sv
// Directed self-checking bench for clk_div_pwm.
module tb_clk_div_pwm;

  logic clk;
  logic rst_n;
  logic enable;
  logic clk_out;
  logic tick;
  logic running;

  int n_checks;
  int n_pass;
  int ph;

  clk_div_pwm_if #(.WIDTH(8)) cfg_if ();

  clk_div_pwm #(
    .WIDTH      (8),
    .DEF_PERIOD (10),
    .DEF_HIGH   (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles of a running waveform; ph is the expected cnt of the sampled cycle.
  task automatic run(input int n, input int per, input int hi);
    for (int i = 0; i < n; i++) begin
      step();
      ph = (ph + 1) % per;
      check("clk_out", 32'(clk_out), 32'(ph < hi));
      check("tick", 32'(tick), 32'(ph == 0));
      check("running", 32'(running), 32'd1);
    end
  endtask

  // Offer a config on the last cycle of the current period: it must wait a full extra period.
  task automatic apply_cfg(input int p, input int h, input int oper, input int ohi);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 8'(p);
    cfg_if.cfg_high   = 8'(h);
    run(1, oper, ohi);
    check("ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    cfg_if.cfg_valid = 1'b0;
    run(oper - 1, oper, ohi);
    ph = -1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_clk_out"}, 32'(clk_out), 32'd0);
    check({tag, "_tick"}, 32'(tick), 32'd0);
    check({tag, "_running"}, 32'(running), 32'd0);
    check({tag, "_ready"}, 32'(cfg_if.cfg_ready), 32'd1);
  endtask

  initial begin
    n_checks          = 0;
    n_pass            = 0;
    ph                = -1;
    rst_n             = 1'b1;
    enable            = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_high   = '0;
    #2 rst_n = 1'b0;
    #2 check_idle("reset");
    step();
    step();
    rst_n = 1'b1;

    // Idle before enable, then defaults 10/5 starting the cycle after enable is sampled
    step();
    step();
    check_idle("idle");
    enable = 1'b1;
    ph = -1;
    run(20, 10, 5);

    // Enable dropped at cnt=2: finish the period, then idle
    run(3, 10, 5);
    enable = 1'b0;
    run(7, 10, 5);
    step();
    check_idle("drained");
    step();
    check_idle("drained2");

    // Config 10/7 offered at cnt=3 applies at the next boundary
    enable = 1'b1;
    ph = -1;
    run(4, 10, 5);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 8'd10;
    cfg_if.cfg_high   = 8'd7;
    run(1, 10, 5);
    check("t2_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    cfg_if.cfg_valid = 1'b0;
    run(5, 10, 5);
    ph = -1;
    run(1, 10, 7);
    check("t2_ready_back", 32'(cfg_if.cfg_ready), 32'd1);
    run(9, 10, 7);

    // 4/0, 4/4, 4/9 (saturated), then period 0 clamped to 1
    apply_cfg(4, 0, 10, 7);
    run(8, 4, 0);
    check("t4_ready", 32'(cfg_if.cfg_ready), 32'd1);
    apply_cfg(4, 4, 4, 0);
    run(8, 4, 4);
    apply_cfg(4, 9, 4, 4);
    run(8, 4, 9);
    apply_cfg(0, 1, 4, 9);
    run(5, 1, 1);

    // Back to 10/5, then reset mid high phase with 20/15 pending
    apply_cfg(10, 5, 1, 1);
    run(3, 10, 5);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = 8'd20;
    cfg_if.cfg_high   = 8'd15;
    run(1, 10, 5);
    cfg_if.cfg_valid = 1'b0;
    check("t6_pending", 32'(cfg_if.cfg_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    step();
    rst_n = 1'b1;
    ph = -1;
    run(20, 10, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
